// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester beat lanes in, FIFO write port out
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   full;
  logic                   w_en;
  logic [DATA_W-1:0]      data_in;
  modport master (output req_valid, req_data, req_last, full, input req_ready, w_en, data_in);
  modport slave (input req_valid, req_data, req_last, full, output req_ready, w_en, data_in);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: frame-granular round-robin sharing of one FIFO write port
module fifo_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DATA_W = 8,
  parameter int IDLE_TO = 16
) (
  input  logic                      wclk,
  input  logic                      arst_n,
  fifo_wr_arbiter_if.slave          bus,
  output logic [NREQ-1:0]           grant,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      abort,
  output logic [15:0]               frame_cnt
);
  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(IDLE_TO + 1);
  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;
  state_t state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0] grant_id_q, grant_id_d, last_id_q, last_id_d, pick_id, cand;
  logic [SW-1:0] stall_q, stall_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic abort_q, abort_d;
  logic xfer, g_valid, fire, done, stall_hit, pick_found;
  assign xfer = state_q == XFER;
  assign g_valid = bus.req_valid[grant_id_q];
  assign fire = xfer & g_valid & ~bus.full;
  assign done = fire & bus.req_last[grant_id_q];
  assign stall_hit = xfer & ~g_valid & (stall_q == SW'(IDLE_TO - 1));
  assign grant = grant_q;
  assign grant_id = grant_id_q;
  assign abort = abort_q;
  assign frame_cnt = frame_cnt_q;
  // Round-robin search beginning just after the previous grantee
  always_comb begin
    pick_found = 1'b0;
    pick_id = '0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_id_q) + k) % NREQ);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id = cand;
      end
    end
  end
  // State register
  always_ff @(posedge wclk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Next state: a frame ends on its last beat or on a stall timeout
  always_comb begin
    state_d = state_q == IDLE ? (|bus.req_valid ? ARB : IDLE) :
              state_q == ARB  ? (pick_found ? XFER : IDLE) :
              state_q == XFER ? ((done | stall_hit) ? IDLE : XFER) : IDLE;
  end
  // Outputs: only the grantee sees ready, and the write path is purely combinational
  always_comb begin
    bus.w_en = fire;
    bus.req_ready = '0;
    bus.req_ready[grant_id_q] = xfer & ~bus.full;
    bus.data_in = xfer ? bus.req_data[grant_id_q*DATA_W +: DATA_W] : '0;
  end
  // Grant, priority pointer, stall timer, frame counter and abort pulse next values
  always_comb begin
    grant_d = grant_q;
    grant_id_d = grant_id_q;
    last_id_d = last_id_q;
    stall_d = (xfer && !g_valid && !stall_hit) ? stall_q + 1'b1 : '0;
    frame_cnt_d = frame_cnt_q + 16'(done);
    abort_d = stall_hit;
    if (state_q == ARB && pick_found) begin
      grant_d = NREQ'(1) << pick_id;
      grant_id_d = pick_id;
    end
    if (done | stall_hit) begin
      grant_d = '0;
      last_id_d = grant_id_q;
    end
  end
  // Datapath registers; last_id resets to the top index so requester 0 wins first
  always_ff @(posedge wclk or negedge arst_n) begin
    if (!arst_n) begin
      grant_q <= '0;
      grant_id_q <= '0;
      last_id_q <= IW'(NREQ - 1);
      stall_q <= '0;
      frame_cnt_q <= '0;
      abort_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q <= last_id_d;
      stall_q <= stall_d;
      frame_cnt_q <= frame_cnt_d;
      abort_q <= abort_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench with a frame-level round-robin model
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DATA_W = 8, IDLE_TO = 16, DEPTH = 256;
  typedef struct packed {logic first; logic last; logic [1:0] id; logic [7:0] d;} exp_t;
  logic wclk = 1'b0, arst_n = 1'b1;
  logic [NREQ-1:0] grant;
  logic [1:0] grant_id;
  logic abort;
  logic [15:0] frame_cnt;
  fifo_wr_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();
  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .IDLE_TO(IDLE_TO)) dut (
    .wclk(wclk), .arst_n(arst_n), .bus(bus), .grant(grant),
    .grant_id(grant_id), .abort(abort), .frame_cnt(frame_cnt));
  always #5 wclk = ~wclk;

  logic [8:0] mem [NREQ][DEPTH];
  int hd [NREQ], tl [NREQ], gap [NREQ];
  bit drop [NREQ];
  bit gap_en = 0, rand_full = 0, full_force = 0, abort_ok = 0;
  exp_t sb [$];
  int checks = 0, errors = 0, nwr = 0, nabort = 0, cyc = 0;
  int wr_cyc = 0, abort_cyc = 0, prev_last_cyc = -100;
  logic [NREQ-1:0] abort_grant = '0;
  int model_last = NREQ - 1, model_frames = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge wclk);
    cyc++;
  end

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge wclk);
      if (bus.full) begin
        chk("full_wen", 32'(bus.w_en), 0);
        chk("full_ready", 32'(bus.req_ready), 0);
      end
      if (!abort_ok) chk("no_abort", 32'(abort), 0);
      if (abort) begin
        nabort++;
        abort_cyc = cyc;
        abort_grant = grant;
      end
      if (bus.w_en) begin
        nwr++;
        wr_cyc = cyc;
        if (sb.size() == 0) chk("wr_unexpected", 32'(bus.w_en), 0);
        else begin
          e = sb.pop_front();
          chk("wr_data", 32'(bus.data_in), 32'(e.d));
          chk("wr_id", 32'(grant_id), 32'(e.id));
          chk("wr_grant", 32'(grant), 32'(4'b1 << e.id));
          if (e.first) chk("frame_gap", 32'(cyc - prev_last_cyc >= 3), 1);
          if (e.last) prev_last_cyc = cyc;
        end
      end
    end
  end

  task automatic present();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = hd[i] < tl[i] && gap[i] == 0;
      bus.req_data[i*DATA_W +: DATA_W] = mem[i][hd[i]][7:0];
      bus.req_last[i] = mem[i][hd[i]][8];
    end
    bus.full = full_force | (rand_full & ($urandom_range(0, 3) == 0));
  endtask

  task automatic tick();
    logic [NREQ-1:0] acc;
    @(negedge wclk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        gap[i] = drop[i] ? 100000 : (gap_en && !mem[i][hd[i]][8]) ? int'($urandom_range(0, 4)) : 0;
        hd[i]++;
      end else if (gap[i] > 0) gap[i]--;
    end
    present();
  endtask

  task automatic add_beat(int id, logic [7:0] d, logic l);
    mem[id][tl[id]] = {l, d};
    tl[id]++;
  endtask

  task automatic add_frame(int id, int len);
    for (int b = 0; b < len; b++) add_beat(id, 8'($urandom), b == len - 1);
  endtask

  // Frame-level model: next grantee is the first requester with a pending frame after the last one
  task automatic plan();
    int p [NREQ];
    int id;
    bit found, first, last;
    for (int i = 0; i < NREQ; i++) p[i] = hd[i];
    while (1) begin
      found = 0;
      id = 0;
      for (int k = 1; k <= NREQ; k++)
        if (!found && p[(model_last + k) % NREQ] < tl[(model_last + k) % NREQ]) begin
          found = 1;
          id = (model_last + k) % NREQ;
        end
      if (!found) break;
      first = 1;
      do begin
        last = mem[id][p[id]][8];
        sb.push_back('{first: first, last: last, id: 2'(id), d: mem[id][p[id]][7:0]});
        first = 0;
        p[id]++;
      end while (!last);
      model_last = id;
      model_frames++;
    end
    present();
  endtask

  task automatic clear_tb();
    for (int i = 0; i < NREQ; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      gap[i] = 0;
      drop[i] = 0;
    end
    sb.delete();
    model_last = NREQ - 1;
    model_frames = 0;
    full_force = 0;
    rand_full = 0;
    gap_en = 0;
    abort_ok = 0;
    present();
  endtask

  task automatic do_reset();
    arst_n = 0;
    clear_tb();
    repeat (2) @(posedge wclk);
    #1 arst_n = 1;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (2) tick();
    chk("grant_idle", 32'(grant), 0);
    chk("frame_cnt", 32'(frame_cnt), 32'(model_frames[15:0]));
  endtask

  initial begin
    int n0, a0, t0, w;
    clear_tb();
    #2 arst_n = 0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_wen", 32'(bus.w_en), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    // single requester, four beats
    do_reset();
    n0 = nwr;
    add_beat(0, 8'h11, 0);
    add_beat(0, 8'h22, 0);
    add_beat(0, 8'h33, 0);
    add_beat(0, 8'h44, 1);
    plan();
    drain(100);
    chk("single_writes", nwr - n0, 4);
    // round robin over all requesters, two-beat frames
    do_reset();
    for (int i = 0; i < NREQ; i++) add_frame(i, 2);
    add_frame(0, 2);
    plan();
    drain(200);
    // back-pressure for 20 cycles mid-frame of requester 1
    add_frame(1, 6);
    plan();
    n0 = nwr;
    a0 = nabort;
    t0 = 0;
    while (nwr < n0 + 2 && t0 < 50) begin
      tick();
      t0++;
    end
    chk("bp_start", nwr - n0, 2);
    full_force = 1;
    present();
    repeat (20) tick();
    chk("bp_held", nwr - n0, 2);
    chk("bp_abort", nabort - a0, 0);
    full_force = 0;
    present();
    drain(100);
    // timeout: requester 2 sends one beat then goes silent
    do_reset();
    abort_ok = 1;
    drop[2] = 1;
    add_beat(2, 8'hA5, 0);
    add_beat(2, 8'h5A, 1);
    add_beat(3, 8'h3C, 1);
    sb.push_back('{first: 1'b1, last: 1'b0, id: 2'd2, d: 8'hA5});
    sb.push_back('{first: 1'b1, last: 1'b1, id: 2'd3, d: 8'h3C});
    model_frames = 1;
    present();
    n0 = nwr;
    a0 = nabort;
    t0 = 0;
    while (nwr == n0 && t0 < 20) begin
      tick();
      t0++;
    end
    chk("to_beat", nwr - n0, 1);
    t0 = wr_cyc;
    w = 0;
    while (nabort == a0 && w < 40) begin
      tick();
      w++;
    end
    chk("to_abort_seen", nabort - a0, 1);
    chk("to_abort_lat", abort_cyc - t0, IDLE_TO + 1);
    chk("to_abort_grant", 32'(abort_grant), 0);
    repeat (3) tick();
    chk("to_abort_pulse", nabort - a0, 1);
    drain(100);
    abort_ok = 0;
    // reset in the middle of a frame
    do_reset();
    add_frame(2, 4);
    plan();
    n0 = nwr;
    t0 = 0;
    while (nwr == n0 && t0 < 20) begin
      tick();
      t0++;
    end
    chk("mid_rst_beat", nwr - n0, 1);
    #2 arst_n = 0;
    #1;
    chk("mid_rst_wen", 32'(bus.w_en), 0);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_grant_id", 32'(grant_id), 0);
    chk("mid_rst_abort", 32'(abort), 0);
    clear_tb();
    add_frame(0, 3);
    add_frame(3, 2);
    plan();
    @(posedge wclk);
    #1 arst_n = 1;
    drain(100);
    // single-beat frames from requesters 1 and 3
    do_reset();
    add_frame(1, 1);
    add_frame(3, 1);
    plan();
    drain(100);
    // randomized frames, gaps and back-pressure
    do_reset();
    gap_en = 1;
    rand_full = 1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NREQ; i++) repeat ($urandom_range(0, 3)) add_frame(i, int'($urandom_range(1, 4)));
      plan();
      drain(600);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
